conv_psum_accumulator: RTL and testbench

- Downstream stage of the convolution controller FSM and the multiplier pool.
- Consumes the stream of per-tap products the multipliers produce and accumulates F*F*K consecutive products into one output pixel.
- Scales and saturates each pixel, then emits it with its (row, col, filter) coordinates to the output feature-map writer.
- Asserts a frame-done pulse after the last pixel of the last filter is emitted.

---
 rtl/conv_psum_if.sv | 30 +++
 rtl/conv_psum_accumulator.sv | 186 ++++++++++++++++++
 tb/tb_conv_psum_accumulator.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_psum_if.sv
// Product-in / pixel-out handshake bundle for conv_psum_accumulator.
// master drives products and accepts pixels; slave is the accumulator.
interface conv_psum_if #(
  parameter int PW = 32,
  parameter int OW = 16,
  parameter int CW = 5,
  parameter int FW = 2
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [PW-1:0] in_prod;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_data;
  logic [CW-1:0]        out_row;
  logic [CW-1:0]        out_col;
  logic [FW-1:0]        out_filt;

  modport master (
    output in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_row, out_col, out_filt
  );

  modport slave (
    input  in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_data,
    output out_row, out_col, out_filt
  );
endinterface

// File: rtl/conv_psum_accumulator.sv
// Accumulates F*F*K products per pixel, scales/saturates, emits with coords.
// Optional macro CONV_ACC_RELU_EN clamps negative scaled values to zero.
module conv_psum_accumulator #(
  parameter int N     = 32,
  parameter int F     = 3,
  parameter int K     = 3,
  parameter int NF    = 3,
  parameter int P     = 1,
  parameter int S     = 1,
  parameter int PW    = 32,
  parameter int AW    = 40,
  parameter int OW    = 16,
  parameter int SHIFT = 0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic       start,
  conv_psum_if.slave bus,
  output logic       busy,
  output logic       frame_done
);
  localparam int OUT_SIZE = (N - F + 2*P) / S + 1;
  localparam int TAPS     = F * F * K;
  localparam int CW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int FW = (NF > 1) ? $clog2(NF) : 1;
  localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;

  localparam logic signed [AW-1:0] SMAX =
    {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN =
    {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE, ACCUM, EMIT
  } state_t;

  state_t state_q, state_d;

  logic signed [AW-1:0] acc_q, acc_d;
  logic [TW-1:0]        tap_q, tap_d;
  logic [CW-1:0]        row_q, row_d;
  logic [CW-1:0]        col_q, col_d;
  logic [FW-1:0]        filt_q, filt_d;
  logic signed [OW-1:0] data_q, data_d;
  logic                 done_q, done_d;

  logic                 in_xfer;
  logic                 out_xfer;
  logic                 tap_last;
  logic                 col_last;
  logic                 row_last;
  logic                 frame_last;
  logic signed [AW-1:0] acc_sum;
  logic signed [AW-1:0] scaled;
  logic signed [OW-1:0] sat_val;

  assign in_xfer  = bus.in_valid && (state_q == ACCUM);
  assign out_xfer = bus.out_ready && (state_q == EMIT);
  assign tap_last = (tap_q == TW'(TAPS - 1));
  assign col_last = (col_q == CW'(OUT_SIZE - 1));
  assign row_last = (row_q == CW'(OUT_SIZE - 1));
  assign frame_last =
    col_last && row_last && (filt_q == FW'(NF - 1));

  assign acc_sum =
    acc_q + {{(AW-PW){bus.in_prod[PW-1]}}, bus.in_prod};

  always_comb begin
    scaled = acc_sum >>> SHIFT;
`ifdef CONV_ACC_RELU_EN
    if (scaled < 0) scaled = '0;
`endif
    unique case (1'b1)
      (scaled > SMAX): sat_val = SMAX[OW-1:0];
      (scaled < SMIN): sat_val = SMIN[OW-1:0];
      default:         sat_val = scaled[OW-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      acc_q   <= '0;
      tap_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      filt_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      tap_q   <= tap_d;
      row_q   <= row_d;
      col_q   <= col_d;
      filt_q  <= filt_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = ACCUM;
      ACCUM: if (in_xfer && tap_last) state_d = EMIT;
      EMIT: begin
        if (out_xfer) state_d = frame_last ? IDLE : ACCUM;
      end
      default: state_d = IDLE;
    endcase
    if (!en) state_d = IDLE;
  end

  always_comb begin
    acc_d  = acc_q;
    tap_d  = tap_q;
    row_d  = row_q;
    col_d  = col_q;
    filt_d = filt_q;
    data_d = data_q;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d  = '0;
          tap_d  = '0;
          row_d  = '0;
          col_d  = '0;
          filt_d = '0;
        end
      end
      ACCUM: begin
        if (in_xfer && tap_last) begin
          data_d = sat_val;
          acc_d  = '0;
          tap_d  = '0;
        end else if (in_xfer) begin
          acc_d = acc_sum;
          tap_d = tap_q + TW'(1);
        end
      end
      EMIT: begin
        if (out_xfer && frame_last) begin
          row_d  = '0;
          col_d  = '0;
          filt_d = '0;
          done_d = 1'b1;
        end else if (out_xfer && col_last) begin
          col_d = '0;
          if (row_last) begin
            row_d  = '0;
            filt_d = filt_q + FW'(1);
          end else begin
            row_d = row_q + CW'(1);
          end
        end else if (out_xfer) begin
          col_d = col_q + CW'(1);
        end
      end
      default: ;
    endcase
    // abort wipes everything, including a pixel offered this cycle
    if (!en) begin
      acc_d  = '0;
      tap_d  = '0;
      row_d  = '0;
      col_d  = '0;
      filt_d = '0;
      data_d = '0;
      done_d = 1'b0;
    end
  end

  always_comb begin
    bus.in_ready  = (state_q == ACCUM);
    bus.out_valid = (state_q == EMIT);
    bus.out_data  = data_q;
    bus.out_row   = row_q;
    bus.out_col   = col_q;
    bus.out_filt  = filt_q;
    busy          = (state_q != IDLE);
    frame_done    = done_q;
  end
endmodule

// File: tb/tb_conv_psum_accumulator.sv
// Directed bench for conv_psum_accumulator at default parameters.
// Drives and samples on the falling clock edge.
module tb_conv_psum_accumulator;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic en = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic frame_done;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  conv_psum_if #(.PW(32), .OW(16), .CW(5), .FW(2)) bus ();

  conv_psum_accumulator dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .start     (start),
    .bus       (bus.slave),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_done) done_cnt++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input logic [31:0] v, input int n,
                      input int gap);
    int got;
    int t;
    got = 0;
    t = 0;
    while (got < n && t < 2000) begin
      bus.in_prod  = v;
      bus.in_valid = !(gap > 0 && (t % gap) == gap - 1);
      if (bus.in_valid && bus.in_ready) got++;
      @(negedge clk);
      t++;
    end
    bus.in_valid = 1'b0;
    if (got < n) chk("feed_timeout", 64'(got), 64'(n));
  endtask

  task automatic get_pixel(input int hold,
                           output logic [15:0] d,
                           output int r, output int c,
                           output int f, output bit stable);
    int t;
    t = 0;
    while (!bus.out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    d = bus.out_data;
    r = int'(bus.out_row);
    c = int'(bus.out_col);
    f = int'(bus.out_filt);
    stable = bus.out_valid && !bus.in_ready;
    bus.in_valid = 1'b1;
    bus.in_prod  = 32'd100;
    repeat (hold) begin
      @(negedge clk);
      if (bus.out_data !== d || !bus.out_valid ||
          bus.in_ready ||
          int'(bus.out_row) != r ||
          int'(bus.out_col) != c ||
          int'(bus.out_filt) != f)
        stable = 1'b0;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  function automatic logic [15:0] model(input longint s);
    longint x;
    x = s;
`ifdef CONV_ACC_RELU_EN
    if (x < 0) x = 0;
`endif
    if (x > 32767) return 16'h7fff;
    if (x < -32768) return 16'h8000;
    return x[15:0];
  endfunction

  logic [15:0] d;
  int r, c, f;
  bit st;
  int bad;
  int npix;
  int base;
  logic [15:0] neg_exp;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_prod   = '0;
    bus.out_ready = 1'b0;
`ifdef CONV_ACC_RELU_EN
    neg_exp = 16'h0000;
`else
    neg_exp = 16'hffca;
`endif
    #12;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_in_ready", 64'(bus.in_ready), 0);
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_data", 64'(bus.out_data), 0);
    chk("rst_done", 64'(frame_done), 0);
    @(negedge clk);
    rstn = 1'b1;
    en = 1'b1;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 0);
    do_start();
    chk("start_busy", 64'(busy), 1);
    chk("accum_ready", 64'(bus.in_ready), 1);

    feed(32'd1, 26, 0);
    chk("lat_not_yet", 64'(bus.out_valid), 0);
    feed(32'd1, 1, 0);
    chk("lat_valid", 64'(bus.out_valid), 1);
    chk("emit_ready", 64'(bus.in_ready), 0);
    get_pixel(0, d, r, c, f, st);
    chk("ones_data", 64'(d), 27);
    chk("ones_coord", 64'({r, c, f}), 64'({32'd0, 32'd0}));

    feed(32'h7fffffff, 27, 0);
    get_pixel(0, d, r, c, f, st);
    chk("pos_sat", 64'(d), 64'h7fff);
    chk("pos_col", 64'(c), 1);

    feed(32'h80000000, 27, 0);
    get_pixel(0, d, r, c, f, st);
    chk("neg_sat", 64'(d), 64'h8000);

    feed(32'hfffffffe, 27, 3);
    get_pixel(0, d, r, c, f, st);
    chk("neg_two", 64'(d), 64'(neg_exp));
    chk("neg_two_col", 64'(c), 3);

    feed(32'd9, 5, 0);
    en = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 0);
    chk("abort_col", 64'(bus.out_col), 0);
    en = 1'b1;
    do_start();
    feed(32'd1, 27, 0);
    get_pixel(5, d, r, c, f, st);
    chk("hold_stable", 64'(st), 1);
    chk("hold_data", 64'(d), 27);
    chk("hold_col", 64'(c), 0);
    feed(32'd2, 27, 0);
    get_pixel(0, d, r, c, f, st);
    chk("after_hold_data", 64'(d), 54);
    chk("after_hold_col", 64'(c), 1);
    chk("after_hold_row", 64'(r), 0);

    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    do_start();
    bad = 0;
    npix = 0;
    base = done_cnt;
    for (int idx = 0; idx < 3072; idx++) begin
      int v;
      v = (idx % 7) - 3;
      feed(32'(v), 27, (idx % 64 == 0) ? 13 : 0);
      if (idx == 3071)
        chk("done_early", 64'(done_cnt - base), 0);
      get_pixel((idx % 128 == 5) ? 2 : 0, d, r, c, f, st);
      npix++;
      if (!st || d !== model(27 * longint'(v)) ||
          f != idx / 1024 || r != (idx / 32) % 32 ||
          c != idx % 32)
        bad++;
    end
    chk("frame_done_pulse", 64'(frame_done), 1);
    chk("frame_busy", 64'(busy), 0);
    @(negedge clk);
    chk("frame_done_drop", 64'(frame_done), 0);
    chk("frame_done_cnt", 64'(done_cnt - base), 1);
    chk("frame_bad_pix", 64'(bad), 0);
    chk("frame_pix_cnt", 64'(npix), 3072);

    do_start();
    repeat (5) begin
      feed(32'd1, 27, 0);
      get_pixel(0, d, r, c, f, st);
    end
    feed(32'd1, 10, 0);
    chk("pre_rst_col", 64'(bus.out_col), 5);
    rstn = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 0);
    chk("arst_ready", 64'(bus.in_ready), 0);
    chk("arst_data", 64'(bus.out_data), 0);
    chk("arst_col", 64'(bus.out_col), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    do_start();
    feed(32'd3, 27, 0);
    get_pixel(0, d, r, c, f, st);
    chk("post_rst_data", 64'(d), 81);
    chk("post_rst_coord", 64'({r, c, f}), 64'({32'd0, 32'd0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
